// File: rtl/signed_divider_pipe.sv
// Sequential signed divider, q = trunc(a*2^FRAC/b): result valid WIDTH+FRAC+2 cycles after accept (1 for b==0).
// One request in flight; result is held in DONE until out_ready, and start is ignored until then.
module signed_divider_pipe #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div0,
  output logic             ovf
);

  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [WIDTH-1:0] MAX_S = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_S = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N-1:0]     dq_q, dq_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH:0]   bmag_q, bmag_d;
  logic             sgnq_q, sgnq_d;
  logic             sgnr_q, sgnr_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             div0_q, div0_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   a_ext, b_ext, amag, bmag;
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] q_sgn, r_sgn;
  logic             ovf_pos, ovf_neg;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dq_d    = dq_q;
    rem_d   = rem_q;
    bmag_d  = bmag_q;
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
    q_d     = q_q;
    r_d     = r_q;
    div0_d  = div0_q;
    ovf_d   = ovf_q;

    // One extra bit keeps |-2^(WIDTH-1)| exact.
    a_ext  = {a[WIDTH-1], a};
    b_ext  = {b[WIDTH-1], b};
    amag   = a[WIDTH-1] ? -a_ext : a_ext;
    bmag   = b[WIDTH-1] ? -b_ext : b_ext;

    rem_sh = {rem_q, dq_q[N-1]};
    ge     = rem_sh >= bmag_q;

    q_sgn   = sgnq_q ? WIDTH'(-dq_q) : WIDTH'(dq_q);
    r_sgn   = sgnr_q ? -rem_q : rem_q;
    ovf_pos = !sgnq_q && (dq_q > N'(MAX_S));
    ovf_neg = sgnq_q && (dq_q > N'(MIN_S));

    case (state_q)
      IDLE: begin
        if (start) begin
          sgnq_d = a[WIDTH-1] ^ b[WIDTH-1];
          sgnr_d = a[WIDTH-1];
          bmag_d = bmag;
          dq_d   = N'(amag) << FRAC;
          rem_d  = '0;
          cnt_d  = '0;
          if (b == '0) begin
            state_d = DONE;
            q_d     = a[WIDTH-1] ? MIN_S : MAX_S;
            r_d     = a;
            div0_d  = 1'b1;
            ovf_d   = 1'b0;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // dq shifts the dividend out of the top while quotient bits enter at the bottom.
        rem_d = ge ? WIDTH'(rem_sh - bmag_q) : rem_sh[WIDTH-1:0];
        dq_d  = {dq_q[N-2:0], ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N-1)) begin
          state_d = FIX;
          cnt_d   = '0;
        end
      end
      FIX: begin
        state_d = DONE;
        div0_d  = 1'b0;
        if (ovf_pos || ovf_neg) begin
          q_d   = ovf_pos ? MAX_S : MIN_S;
          r_d   = '0;
          ovf_d = 1'b1;
        end else begin
          q_d   = q_sgn;
          r_d   = r_sgn;
          ovf_d = 1'b0;
        end
      end
      default: begin
        if (out_ready) begin
          state_d = IDLE;
          q_d     = '0;
          r_d     = '0;
          div0_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dq_q    <= '0;
      rem_q   <= '0;
      bmag_q  <= '0;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dq_q    <= dq_d;
      rem_q   <= rem_d;
      bmag_q  <= bmag_d;
      sgnq_q  <= sgnq_d;
      sgnr_q  <= sgnr_d;
      q_q     <= q_d;
      r_q     <= r_d;
      div0_q  <= div0_d;
      ovf_q   <= ovf_d;
    end
  end

  // Result registers are zero outside DONE, so no output gating is needed.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign q         = q_q;
  assign r         = r_q;
  assign div0      = div0_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_signed_divider_pipe.sv
// Directed bench for signed_divider_pipe: 32-bit integer instance and 16-bit Q15 instance.
module tb_signed_divider_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        start32, in_ready32, out_valid32, out_ready32, div032, ovf32;
  logic [31:0] a32, b32, q32, r32;
  logic        start16, in_ready16, out_valid16, out_ready16, div016, ovf16;
  logic [15:0] a16, b16, q16, r16;

  signed_divider_pipe #(.WIDTH(32), .FRAC(0)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .in_ready(in_ready32),
    .a(a32), .b(b32), .out_valid(out_valid32), .out_ready(out_ready32),
    .q(q32), .r(r32), .div0(div032), .ovf(ovf32)
  );

  signed_divider_pipe #(.WIDTH(16), .FRAC(15)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .in_ready(in_ready16),
    .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16),
    .q(q16), .r(r16), .div0(div016), .ovf(ovf16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, check latency and result, optionally stall hold cycles, then consume.
  task automatic div32(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] eq, input logic [31:0] er,
                       input logic ediv0, input logic eovf, input int elat, input int hold);
    int n;
    int lat;
    n = 0;
    while (!in_ready32 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_ready"}, in_ready32, 1'b1);
    a32 = av; b32 = bv; start32 = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0;
    a32 = $urandom; b32 = $urandom;
    lat = 1;
    @(negedge clk);
    while (!out_valid32 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(elat));
    check({tag, "_q"}, q32, eq);
    check({tag, "_r"}, r32, er);
    check({tag, "_div0"}, div032, ediv0);
    check({tag, "_ovf"}, ovf32, eovf);
    check({tag, "_busy"}, in_ready32, 1'b0);
    for (int i = 0; i < hold; i++) begin
      start32 = 1'b1;
      @(negedge clk);
      check({tag, "_hold_q"}, q32, eq);
      check({tag, "_hold_r"}, r32, er);
      check({tag, "_hold_vld"}, out_valid32, 1'b1);
      check({tag, "_hold_rdy"}, in_ready32, 1'b0);
    end
    start32 = 1'b0;
    out_ready32 = 1'b1;
    @(posedge clk);
    #1 out_ready32 = 1'b0;
    check({tag, "_post_vld"}, out_valid32, 1'b0);
    check({tag, "_post_q"}, q32, 32'd0);
    check({tag, "_post_r"}, r32, 32'd0);
    check({tag, "_post_flags"}, {div032, ovf32}, 2'b00);
    check({tag, "_post_rdy"}, in_ready32, 1'b1);
  endtask

  task automatic div16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input logic [15:0] eq, input logic [15:0] er,
                       input logic eovf, input int elat);
    int lat;
    a16 = av; b16 = bv; start16 = 1'b1;
    @(posedge clk);
    #1 start16 = 1'b0;
    a16 = 16'hA5A5; b16 = 16'h0000;
    lat = 1;
    @(negedge clk);
    while (!out_valid16 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(elat));
    check({tag, "_q"}, q16, eq);
    check({tag, "_r"}, r16, er);
    check({tag, "_ovf"}, ovf16, eovf);
    check({tag, "_div0"}, div016, 1'b0);
    out_ready16 = 1'b1;
    @(posedge clk);
    #1 out_ready16 = 1'b0;
    check({tag, "_post_vld"}, out_valid16, 1'b0);
  endtask

  initial begin
    logic seen;
    int   n;
    rst = 1'b1;
    start32 = 1'b0; out_ready32 = 1'b0; a32 = '0; b32 = '0;
    start16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0;
    #1;
    check("reset_in_ready", in_ready32, 1'b1);
    check("reset_out_valid", out_valid32, 1'b0);
    check("reset_q_r", {q32, r32}, 64'd0);
    check("reset_flags", {div032, ovf32}, 2'b00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    div32("pos_pos", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 34, 0);
    div32("neg_pos", -32'sd100, 32'd7, -32'sd14, -32'sd2, 1'b0, 1'b0, 34, 0);
    div32("pos_neg", 32'd100, -32'sd7, -32'sd14, 32'd2, 1'b0, 1'b0, 34, 0);
    div32("small_big", 32'd7, -32'sd100, 32'd0, 32'd7, 1'b0, 1'b0, 34, 0);
    div32("div0_pos", 32'd5, 32'd0, 32'h7FFF_FFFF, 32'd5, 1'b1, 1'b0, 1, 0);
    div32("div0_neg", -32'sd5, 32'd0, 32'h8000_0000, -32'sd5, 1'b1, 1'b0, 1, 0);
    div32("min_by_m1", 32'h8000_0000, -32'sd1, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b1, 34, 0);
    div32("min_by_1", 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 34, 0);
    div32("hold", 32'd1000, -32'sd33, -32'sd30, 32'd10, 1'b0, 1'b0, 34, 10);

    div16("q15_third", 16'd1, 16'd3, 16'd10922, 16'd2, 1'b0, 33);
    div16("q15_ovf", 16'd2, 16'd1, 16'h7FFF, 16'd0, 1'b1, 33);

    // Reset during RUN: request is dropped and never completes.
    @(negedge clk);
    a32 = 32'd100; b32 = 32'd7; start32 = 1'b1; out_ready32 = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_run_in_ready", in_ready32, 1'b1);
    check("rst_run_out_valid", out_valid32, 1'b0);
    check("rst_run_q", q32, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      seen = seen | out_valid32;
    end
    check("rst_run_no_valid", seen, 1'b0);

    // Reset while a result is waiting in DONE clears it without a clock edge.
    out_ready32 = 1'b0;
    a32 = 32'd1000; b32 = -32'sd33; start32 = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0;
    n = 0;
    while (!out_valid32 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_done_reached", out_valid32, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_done_out_valid", out_valid32, 1'b0);
    check("rst_done_q_r", {q32, r32}, 64'd0);
    check("rst_done_in_ready", in_ready32, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    div32("after_rst", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 34, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
